// File: rtl/async_fifo_wr_arbiter_pkg.sv
// async_fifo_rtl_pkg: shared types and helpers for the async FIFO write-side arbiter
package async_fifo_rtl_pkg;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/async_fifo_wr_arbiter_if.sv
// async_fifo_wr_arbiter_if: requester handshakes plus the FIFO write port seen by the arbiter
interface async_fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int GW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wfull;
  logic                          winc;
  logic [DATA_WIDTH-1:0]         wdata;
  logic [GW-1:0]                 gnt_id;
  logic                          busy;
  modport master (
    output req_valid, req_data, wfull,
    input  req_ready, winc, wdata, gnt_id, busy
  );
  modport slave (
    input  req_valid, req_data, wfull,
    output req_ready, winc, wdata, gnt_id, busy
  );
endinterface

// File: rtl/async_fifo_wr_arbiter_rr_pick.sv
// rr_pick: round-robin pick of the first set request after last_gnt via rotate-and-priority-encode
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_gnt,
  output logic         found,
  output logic [W-1:0] idx
);
  int start;
  int sel;
  logic [N-1:0] rot;
  always_comb begin
    start = (int'(last_gnt) + 1) % N;
    rot = N'({req, req} >> start);
    found = |rot;
    sel = 0;
    for (int j = N - 1; j >= 0; j--) sel = rot[j] ? j : sel;
    idx = W'((start + sel) % N);
  end
endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// async_fifo_wr_arbiter: round-robin burst arbiter sharing one async FIFO write port
module async_fifo_wr_arbiter
  import async_fifo_rtl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input logic wclk,
  input logic wrst,
  async_fifo_wr_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = clog2_min1(MAX_BURST);
  arb_state_e state, state_nxt;
  logic [GW-1:0] gnt_id, last_gnt, pick;
  logic [BW-1:0] beat_cnt;
  logic found, gnt_valid, winc, last_beat;
  rr_pick #(.N(NUM_REQ), .W(GW)) u_pick (
    .req     (bus.req_valid),
    .last_gnt(last_gnt),
    .found   (found),
    .idx     (pick)
  );
  always_comb begin
    gnt_valid = bus.req_valid[gnt_id];
    winc = (state == ARB_BURST) && gnt_valid && !bus.wfull;
    last_beat = beat_cnt == BW'(MAX_BURST - 1);
    state_nxt = (state == ARB_IDLE) ? (found ? ARB_BURST : ARB_IDLE)
              : ((!gnt_valid || (winc && last_beat)) ? ARB_IDLE : ARB_BURST);
  end
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state <= ARB_IDLE;
      gnt_id <= '0;
      last_gnt <= GW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && found) begin
        gnt_id <= pick;
        last_gnt <= pick;
        beat_cnt <= '0;
      end else if (winc) begin
        beat_cnt <= beat_cnt + BW'(1);
      end
    end
  end
  // state resets asynchronously, so winc/req_ready drop the moment wrst rises
  assign bus.winc = winc;
  assign bus.req_ready = winc ? (NUM_REQ'(1) << gnt_id) : '0;
  assign bus.wdata = (state == ARB_BURST) ? bus.req_data[gnt_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.gnt_id = gnt_id;
  assign bus.busy = state == ARB_BURST;
endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// tb_async_fifo_wr_arbiter: directed stimulus with a per-cycle behavioural model and scoreboard
module tb_async_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, MB = 4;
  logic wclk = 0;
  logic wrst = 1;
  always #5 wclk = ~wclk;
  async_fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus();
  async_fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wclk(wclk),
    .wrst(wrst),
    .bus (bus)
  );
  int n_pass = 0, n_total = 0;
  int rem[N], seq[N], acc_cnt[N], exp_seq[N];
  int glog[$];
  bit mbusy, prev_busy;
  int mgnt, mlast, mbeats;
  logic ev;
  logic [N-1:0] er;
  logic [DW-1:0] ed;
  function automatic logic [DW-1:0] word(int i, int s);
    return DW'(i * 64 + s % 64);
  endfunction
  task automatic chk(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask
  task automatic drive();
    logic [N-1:0] v;
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) begin
      v[i] = rem[i] > 0;
      d[i*DW +: DW] = word(i, seq[i]);
    end
    bus.req_valid = v;
    bus.req_data = d;
  endtask
  task automatic cyc();
    logic [N-1:0] acc;
    @(negedge wclk);
    acc = bus.req_valid & bus.req_ready;
    @(posedge wclk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        seq[i]++;
        rem[i]--;
        acc_cnt[i]++;
      end
    drive();
  endtask
  // model: expected outputs from the grant rules; words checked in per-requester order
  always @(negedge wclk) begin
    if (wrst) begin
      mbusy = 0;
      mlast = N - 1;
      prev_busy = 0;
    end else begin
      ev = mbusy && bus.req_valid[mgnt] && !bus.wfull;
      er = ev ? (N'(1) << mgnt) : '0;
      ed = mbusy ? word(mgnt, exp_seq[mgnt]) : '0;
      chk("m_busy", bus.busy, mbusy);
      chk("m_winc", bus.winc, ev);
      chk("m_ready", bus.req_ready, er);
      chk("m_wdata", bus.wdata, ed);
      if (mbusy) chk("m_gnt", bus.gnt_id, mgnt);
      if (bus.busy && !prev_busy) glog.push_back(int'(bus.gnt_id));
      prev_busy = bus.busy;
      if (!mbusy) begin
        for (int k = 1; k <= N && !mbusy; k++)
          if (bus.req_valid[(mlast + k) % N]) begin
            mgnt = (mlast + k) % N;
            mlast = mgnt;
            mbeats = 0;
            mbusy = 1;
          end
      end else if (!bus.req_valid[mgnt]) begin
        mbusy = 0;
      end else if (ev) begin
        exp_seq[mgnt]++;
        mbeats++;
        if (mbeats == MB) mbusy = 0;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int base, sum;
    for (int i = 0; i < N; i++) begin
      rem[i] = 1;
      seq[i] = 0;
      acc_cnt[i] = 0;
      exp_seq[i] = 0;
    end
    bus.wfull = 0;
    drive();
    repeat (3) begin
      @(negedge wclk);
      chk("rst_winc", bus.winc, 0);
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_wdata", bus.wdata, 0);
    end
    for (int i = 0; i < N; i++) rem[i] = 8;
    drive();
    @(posedge wclk);
    #1 wrst = 0;
    cyc();
    chk("first_gnt", bus.gnt_id, 0);
    chk("first_busy", bus.busy, 1);
    repeat (24) cyc();
    sum = 0;
    for (int i = 0; i < N; i++) sum += acc_cnt[i];
    chk("rr_beats_25cyc", sum, 20);
    chk("rr_glog_size", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("rr_order", glog[i], i % N);
    chk("rr_cnt0", acc_cnt[0], 8);
    chk("rr_cnt1", acc_cnt[1], 4);
    chk("rr_cnt3", acc_cnt[3], 4);
    for (int i = 0; i < N; i++) rem[i] = 0;
    drive();
    repeat (2) cyc();
    chk("rr_drop_idle", bus.busy, 0);
    base = acc_cnt[2];
    rem[2] = 3;
    drive();
    repeat (8) cyc();
    chk("solo_beats", acc_cnt[2] - base, 3);
    chk("solo_gnt", glog[$], 2);
    chk("solo_idle", bus.busy, 0);
    base = acc_cnt[1];
    rem[1] = 6;
    drive();
    for (int t = 0; t < 10 && acc_cnt[1] == base; t++) cyc();
    chk("full_first_beat", acc_cnt[1] - base, 1);
    bus.wfull = 1;
    #1;
    for (int t = 0; t < 5; t++) begin
      chk("full_winc", bus.winc, 0);
      chk("full_gnt", bus.gnt_id, 1);
      chk("full_busy", bus.busy, 1);
      cyc();
    end
    chk("full_no_beats", acc_cnt[1] - base, 1);
    bus.wfull = 0;
    for (int t = 0; t < 10 && bus.busy; t++) cyc();
    chk("full_burst_len", acc_cnt[1] - base, 4);
    chk("full_burst_end", bus.busy, 0);
    rem[1] = 0;
    drive();
    repeat (3) cyc();
    rem[3] = 10;
    bus.wfull = 1;
    drive();
    cyc();
    chk("stall_gnt", bus.gnt_id, 3);
    chk("stall_busy", bus.busy, 1);
    repeat (2) cyc();
    chk("stall_winc", bus.winc, 0);
    rem[3] = 0;
    rem[0] = 2;
    rem[2] = 2;
    drive();
    cyc();
    chk("stall_drop_idle", bus.busy, 0);
    cyc();
    chk("stall_next_gnt", bus.gnt_id, 0);
    chk("stall_next_busy", bus.busy, 1);
    bus.wfull = 0;
    repeat (12) cyc();
    chk("stall_drained", rem[0] + rem[2], 0);
    base = acc_cnt[1];
    rem[1] = 10;
    drive();
    for (int t = 0; t < 12 && acc_cnt[1] - base < 2; t++) cyc();
    chk("rst_mid_beats", acc_cnt[1] - base, 2);
    #2;
    chk("rst_mid_pre_winc", bus.winc, 1);
    wrst = 1;
    #1;
    chk("rst_mid_winc", bus.winc, 0);
    chk("rst_mid_ready", bus.req_ready, 0);
    chk("rst_mid_busy", bus.busy, 0);
    @(posedge wclk);
    #1 wrst = 0;
    rem[0] = 2;
    drive();
    cyc();
    chk("rst_regrant", bus.gnt_id, 0);
    repeat (30) cyc();
    chk("rst_total1", acc_cnt[1] - base, 10);
    chk("rst_rem1", rem[1], 0);
    chk("rst_seq1", exp_seq[1], seq[1]);
    chk("rst_seq0", exp_seq[0], seq[0]);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
